// File: rtl/axi_mem_pkg.sv
// Shared definitions for the on-chip AXI burst memory responder:
// FSM encodings, beat geometry and arbitration grant encoding.
package axi_mem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_WRESP = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    localparam int BUS_DATA_WIDTH = 32;
    // Addresses count 16-bit DQ words, so one beat advances the address by this much.
    localparam int BEAT_STEP = BUS_DATA_WIDTH / 16;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Neither the array nor the read register is reset.
module sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // Read register doubles as the read-data holding register during stalls.
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI burst memory responder: accepts write bursts into a RAM and streams
// read bursts back with rready backpressure. Drop-in for ddr2_ctrl's axi_* ports.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic                  axi_wlast,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic                  axi_rlast,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic                  err_wlast
);

    localparam int STEP_SH = $clog2(BEAT_STEP);

    logic [1:0]            state_reg, state_next;
    grant_e                last_grant_reg, last_grant_next;
    logic [MEM_AW-1:0]     base_reg, base_next;
    logic [7:0]            len_reg, len_next;
    logic [8:0]            beat_reg, beat_next;
    logic                  rvalid_reg, rvalid_next;
    logic                  rlast_reg, rlast_next;
    logic                  err_wlast_reg, err_wlast_next;

    logic                  grant_wr, grant_rd, wr_fire, rd_en, beat_is_last;
    logic [MEM_AW-1:0]     mem_idx;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  unused_addr_bits;

    // Only the beat-index slice of each address reaches the RAM.
    assign unused_addr_bits = ^{axi_awaddr, axi_araddr};

    // Contested grants alternate; a lone request always wins.
    assign grant_wr = (state_reg == ST_IDLE) && axi_awvalid
                      && (!axi_arvalid || last_grant_reg == GNT_RD);
    assign grant_rd = (state_reg == ST_IDLE) && axi_arvalid && !grant_wr;

    assign beat_is_last = (beat_reg == {1'b0, len_reg});
    assign wr_fire      = (state_reg == ST_WRITE) && axi_wvalid;
    assign rd_en        = (state_reg == ST_READ) && (!rvalid_reg || axi_rready)
                          && (beat_reg <= {1'b0, len_reg});
    assign mem_idx      = base_reg + MEM_AW'(beat_reg);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        base_next       = base_reg;
        len_next        = len_reg;
        beat_next       = beat_reg;
        rvalid_next     = rvalid_reg;
        rlast_next      = rlast_reg;
        err_wlast_next  = err_wlast_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_wr) begin
                    state_next      = ST_WRITE;
                    base_next       = axi_awaddr[MEM_AW+STEP_SH-1 -: MEM_AW];
                    len_next        = axi_awlen;
                    beat_next       = '0;
                    last_grant_next = GNT_WR;
                end else if (grant_rd) begin
                    state_next      = ST_READ;
                    base_next       = axi_araddr[MEM_AW+STEP_SH-1 -: MEM_AW];
                    len_next        = axi_arlen;
                    beat_next       = '0;
                    last_grant_next = GNT_RD;
                end
            end
            ST_WRITE: begin
                // Burst length comes from awlen; wlast only feeds the error flag.
                if (axi_wvalid) begin
                    beat_next = beat_reg + 9'd1;
                    if (axi_wlast != beat_is_last) begin
                        err_wlast_next = 1'b1;
                    end
                    if (beat_is_last) begin
                        state_next = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (axi_bready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    beat_next   = beat_reg + 9'd1;
                    rvalid_next = 1'b1;
                    rlast_next  = beat_is_last;
                end else if (axi_rready) begin
                    rvalid_next = 1'b0;
                    rlast_next  = 1'b0;
                end
                if (rvalid_reg && axi_rready && rlast_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GNT_RD;
            base_reg       <= '0;
            len_reg        <= '0;
            beat_reg       <= '0;
            rvalid_reg     <= 1'b0;
            rlast_reg      <= 1'b0;
            err_wlast_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            base_reg       <= base_next;
            len_reg        <= len_next;
            beat_reg       <= beat_next;
            rvalid_reg     <= rvalid_next;
            rlast_reg      <= rlast_next;
            err_wlast_reg  <= err_wlast_next;
        end
    end

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (mem_idx),
        .wdata (axi_wdata),
        .re    (rd_en),
        .raddr (mem_idx),
        .rdata (ram_q)
    );

    // The RAM register is not reset, so rdata is qualified by rvalid to read 0 after reset.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rdata
            assign axi_rdata[gi] = ram_q[gi] & rvalid_reg;
        end
    endgenerate

    assign axi_awready = grant_wr;
    assign axi_arready = grant_rd;
    assign axi_wready  = (state_reg == ST_WRITE);
    assign axi_bvalid  = (state_reg == ST_WRESP);
    assign axi_rvalid  = rvalid_reg;
    assign axi_rlast   = rlast_reg;
    assign err_wlast   = err_wlast_reg;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: a reference memory predicts read beats,
// which are queued at AR time and popped as the DUT hands them over.
module tb_axi_mem_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axi_awvalid = 1'b0, axi_awready;
    logic [27:0] axi_awaddr = '0;
    logic [7:0]  axi_awlen = '0;
    logic        axi_wvalid = 1'b0, axi_wready, axi_wlast = 1'b0;
    logic [31:0] axi_wdata = '0;
    logic        axi_bvalid, axi_bready = 1'b1;
    logic        axi_arvalid = 1'b0, axi_arready;
    logic [27:0] axi_araddr = '0;
    logic [7:0]  axi_arlen = '0;
    logic        axi_rvalid, axi_rready = 1'b0, axi_rlast;
    logic [31:0] axi_rdata;
    logic        err_wlast;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [1024];
    logic [31:0] wr_buf [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    axi_mem_slave #(.ADDR_WIDTH(28), .DATA_WIDTH(32), .MEM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wlast(axi_wlast), .axi_wdata(axi_wdata),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
        .err_wlast(err_wlast)
    );

    function automatic int midx(input logic [27:0] a, input int b);
        logic [27:0] x;
        x = a + 28'(2 * b);
        return int'(x[10:1]);
    endfunction

    // Both address readies must never be high together.
    always @(negedge clk) begin
        #2;
        if (!rst && (axi_awready || axi_arready)) begin
            n_cmp++;
            if (axi_awready && axi_arready) begin
                n_bad++;
                $display("FAIL ready_exclusive: awready=%b arready=%b, required not both 1",
                         axi_awready, axi_arready);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_awready();
        int t = 0;
        #1;
        while (!axi_awready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        n_cmp++;
        if (axi_awready !== 1'b1) begin
            n_bad++;
            $display("FAIL aw_grant: awready=%b, required 1", axi_awready);
        end
    endtask

    task automatic wait_arready();
        int t = 0;
        #1;
        while (!axi_arready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        n_cmp++;
        if (axi_arready !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_grant: arready=%b, required 1", axi_arready);
        end
    endtask

    // Call just before the AW handshake edge; streams wr_buf[0..len] at one beat per cycle.
    task automatic w_data(input logic [27:0] addr, input int len, input int wlast_at);
        for (int b = 0; b <= len; b++) begin
            @(negedge clk);
            if (b == 0) axi_awvalid = 1'b0;
            axi_wvalid = 1'b1;
            axi_wdata  = wr_buf[b];
            axi_wlast  = (b == wlast_at);
            #1;
            n_cmp++;
            if (axi_wready !== 1'b1) begin
                n_bad++;
                $display("FAIL wready beat %0d: wready=%b, required 1", b, axi_wready);
            end
            model_mem[midx(addr, b)] = wr_buf[b];
        end
        @(negedge clk);
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        #1;
        n_cmp++;
        if (axi_bvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL bvalid_rise: bvalid=%b, required 1", axi_bvalid);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (axi_bvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL bvalid_pulse: bvalid=%b, required 0", axi_bvalid);
        end
        $display("write burst addr=%h len=%0d wlast_at=%0d err_wlast=%b", addr, len, wlast_at, err_wlast);
    endtask

    // Call just before the AR handshake edge; toggle=1 drives rready 1-0-1 each cycle.
    task automatic r_collect(input logic [27:0] addr, input int len, input bit toggle);
        int          cyc = 0;
        bit          seen = 0;
        bit          stalled = 0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        exp_t        e;
        for (int b = 0; b <= len; b++) begin
            e.d = model_mem[midx(addr, b)];
            e.l = (b == len);
            sb.push_back(e);
        end
        while (sb.size() > 0 && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) axi_arvalid = 1'b0;
            axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            cyc++;
            if (axi_rvalid && !seen) begin
                seen = 1;
                n_cmp++;
                if (cyc != 2) begin
                    n_bad++;
                    $display("FAIL rvalid_latency: first rvalid %0d cycles after AR, required 2", cyc);
                end
            end
            if (stalled) begin
                n_cmp++;
                if (axi_rdata !== held_d || axi_rlast !== held_l) begin
                    n_bad++;
                    $display("FAIL stall_hold: rdata=%h rlast=%b, required %h %b",
                             axi_rdata, axi_rlast, held_d, held_l);
                end
            end
            if (axi_rvalid && axi_rready) begin
                e = sb.pop_front();
                n_cmp++;
                if (axi_rdata !== e.d || axi_rlast !== e.l) begin
                    n_bad++;
                    $display("FAIL rbeat: rdata=%h rlast=%b, required %h %b",
                             axi_rdata, axi_rlast, e.d, e.l);
                end
            end
            stalled = axi_rvalid && !axi_rready;
            held_d  = axi_rdata;
            held_l  = axi_rlast;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_timeout: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        axi_rready = 1'b1;
        #1;
        n_cmp++;
        if (axi_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL read_extra_beat: rvalid=%b after rlast, required 0", axi_rvalid);
        end
        $display("read burst addr=%h len=%0d toggle=%0d", addr, len, toggle);
    endtask

    task automatic do_write(input logic [27:0] addr, input int len, input int wlast_at);
        @(negedge clk);
        axi_awvalid = 1'b1;
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        wait_awready();
        w_data(addr, len, wlast_at);
    endtask

    task automatic do_read(input logic [27:0] addr, input int len, input bit toggle);
        @(negedge clk);
        axi_arvalid = 1'b1;
        axi_araddr  = addr;
        axi_arlen   = 8'(len);
        wait_arready();
        r_collect(addr, len, toggle);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast, err_wlast} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: aw=%b ar=%b w=%b b=%b rv=%b rl=%b err=%b, required all 0",
                     axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast, err_wlast);
        end
        n_cmp++;
        if (axi_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: rdata=%h, required 0", axi_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    // Contested AW/AR from reset: write first, then read, then write again.
    task automatic test_arbitration();
        for (int b = 0; b < 8; b++) wr_buf[b] = 32'(b + 1);
        @(negedge clk);
        axi_awvalid = 1'b1; axi_awaddr = 28'h0; axi_awlen = 8'd7;
        axi_arvalid = 1'b1; axi_araddr = 28'h0; axi_arlen = 8'd7;
        #1;
        n_cmp++;
        if (axi_awready !== 1'b1 || axi_arready !== 1'b0) begin
            n_bad++;
            $display("FAIL first_contest: awready=%b arready=%b, required 1 0", axi_awready, axi_arready);
        end
        w_data(28'h0, 7, 7);
        for (int b = 0; b < 4; b++) wr_buf[b] = 32'hA000_0000 + 32'(b);
        axi_awvalid = 1'b1; axi_awaddr = 28'h80; axi_awlen = 8'd3;
        #1;
        n_cmp++;
        if (axi_arready !== 1'b1 || axi_awready !== 1'b0) begin
            n_bad++;
            $display("FAIL second_contest: awready=%b arready=%b, required 0 1", axi_awready, axi_arready);
        end
        r_collect(28'h0, 7, 1'b0);
        n_cmp++;
        if (axi_awready !== 1'b1) begin
            n_bad++;
            $display("FAIL pending_write: awready=%b, required 1", axi_awready);
        end
        w_data(28'h80, 3, 3);
        n_cmp++;
        if (err_wlast !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clean: err_wlast=%b, required 0", err_wlast);
        end
    endtask

    task automatic test_long_read_stall();
        for (int b = 0; b < 32; b++) wr_buf[b] = $urandom;
        do_write(28'h400, 31, 31);
        do_read(28'h400, 31, 1'b1);
    endtask

    task automatic test_wlast_error();
        for (int b = 0; b < 4; b++) wr_buf[b] = 32'h5EED_0000 + 32'(b);
        do_write(28'h200, 3, 2);
        n_cmp++;
        if (err_wlast !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: err_wlast=%b, required 1", err_wlast);
        end
        do_read(28'h200, 3, 1'b0);
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 4; b++) wr_buf[b] = 32'hC0DE_0000 + 32'(b);
        do_write(28'd2044, 3, 3);
        do_read(28'd2044, 3, 1'b0);
        do_read(28'h0, 1, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        int   popped = 0;
        int   cyc = 0;
        exp_t e;
        n_cmp++;
        if (err_wlast !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: err_wlast=%b, required 1", err_wlast);
        end
        @(negedge clk);
        axi_arvalid = 1'b1; axi_araddr = 28'h0; axi_arlen = 8'd7;
        wait_arready();
        for (int b = 0; b < 8; b++) begin
            e.d = model_mem[midx(28'h0, b)];
            e.l = (b == 7);
            sb.push_back(e);
        end
        while (popped < 5 && cyc < 50) begin
            @(negedge clk);
            if (cyc == 0) axi_arvalid = 1'b0;
            axi_rready = 1'b1;
            #1;
            cyc++;
            if (axi_rvalid && axi_rready) begin
                e = sb.pop_front();
                popped++;
                n_cmp++;
                if (axi_rdata !== e.d) begin
                    n_bad++;
                    $display("FAIL pre_reset_beat: rdata=%h, required %h", axi_rdata, e.d);
                end
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (axi_rvalid !== 1'b1 || axi_rdata !== sb[0].d) begin
            n_bad++;
            $display("FAIL beat5_present: rvalid=%b rdata=%h, required 1 %h", axi_rvalid, axi_rdata, sb[0].d);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast, err_wlast} !== 7'b0) begin
            n_bad++;
            $display("FAIL midreset_ctrl: aw=%b ar=%b w=%b b=%b rv=%b rl=%b err=%b, required all 0",
                     axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast, err_wlast);
        end
        n_cmp++;
        if (axi_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset_rdata: rdata=%h, required 0", axi_rdata);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("reset asserted mid-read at beat 5 and released");
        do_read(28'h0, 7, 1'b0);
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_long_read_stall();
        test_wlast_error();
        test_wrap();
        test_reset_mid_read();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
